// File: rtl/result_dispatch_pkg.sv
// result_dispatch_pkg: shared constants and bus FSM encodings for result_dispatcher
// Contents: destination mask bit indices, fixed mask width, stall counter width,
//           bus request FSM state type.
package result_dispatch_pkg;
  localparam int DEST_W       = 3;
  localparam int DEST_INTERIM = 0;
  localparam int DEST_NEIGH   = 1;
  localparam int DEST_BUS     = 2;
  localparam int STALL_W      = 16;
  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_REQ  = 2'd1,
    B_XFER = 2'd2
  } bus_state_e;
endpackage

// File: rtl/result_dispatcher_bus_req_fsm.sv
// bus_req_fsm: request/grant handshake ending in a one-cycle data strobe
// Ports: clk, reset (sync, active-high); start_i begins a request from idle;
//        grant_i arbiter grant (only honoured while requesting);
//        req_o bus request; strobe_o one-cycle data strobe; busy_o transfer outstanding.
module bus_req_fsm
  import result_dispatch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic grant_i,
  output logic req_o,
  output logic strobe_o,
  output logic busy_o
);
  bus_state_e state_q;
  logic       req_q;
  logic       strobe_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= B_IDLE;
      req_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      case (state_q)
        B_IDLE: if (start_i) begin
          state_q <= B_REQ;
          req_q   <= 1'b1;
        end
        B_REQ: if (grant_i) begin
          state_q  <= B_XFER;
          req_q    <= 1'b0;
          strobe_q <= 1'b1;
        end
        B_XFER: begin
          state_q  <= B_IDLE;
          strobe_q <= 1'b0;
        end
        default: begin
          state_q  <= B_IDLE;
          req_q    <= 1'b0;
          strobe_q <= 1'b0;
        end
      endcase
    end
  end
  assign req_o    = req_q;
  assign strobe_o = strobe_q;
  assign busy_o   = state_q != B_IDLE;
endmodule

// File: rtl/result_dispatcher.sv
// result_dispatcher: multicasts each ALU result to interim buffer, neighbour PE and shared bus
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_data/in_dest/in_addr result input;
//        interim_wr_* one-cycle write port; neigh_valid/neigh_ready/neigh_data neighbour handshake;
//        bus_req/bus_grant/bus_valid/bus_data shared bus master; stall_cnt input stall counter.
// Build option: define RESULT_DISPATCHER_STALL_CNT_EN to build the saturating stall counter;
//        otherwise stall_cnt is tied to 0.
module result_dispatcher
  import result_dispatch_pkg::*;
#(
  parameter int LEN    = 8,
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LEN-1:0]     in_data,
  input  logic [DEST_W-1:0]  in_dest,
  input  logic [ADDR_W-1:0]  in_addr,
  output logic               interim_wr_en,
  output logic [ADDR_W-1:0]  interim_wr_addr,
  output logic [LEN-1:0]     interim_wr_data,
  output logic               neigh_valid,
  input  logic               neigh_ready,
  output logic [LEN-1:0]     neigh_data,
  output logic               bus_req,
  input  logic               bus_grant,
  output logic               bus_valid,
  output logic [LEN-1:0]     bus_data,
  output logic [STALL_W-1:0] stall_cnt
);
  logic              accept;
  logic              bus_pend;
  logic [LEN-1:0]    data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic              neigh_q, neigh_d;
  // data_q only moves on accept, and accept needs both paths idle, so it is stable while offered
  always_comb begin
    accept  = in_valid & in_ready;
    data_d  = accept ? in_data : data_q;
    addr_d  = accept ? in_addr : addr_q;
    wr_d    = accept & in_dest[DEST_INTERIM];
    neigh_d = accept ? in_dest[DEST_NEIGH] : neigh_q & ~neigh_ready;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      neigh_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      neigh_q <= neigh_d;
    end
  end
  bus_req_fsm u_bus (
    .clk      (clk),
    .reset    (reset),
    .start_i  (accept & in_dest[DEST_BUS]),
    .grant_i  (bus_grant),
    .req_o    (bus_req),
    .strobe_o (bus_valid),
    .busy_o   (bus_pend)
  );
  assign in_ready        = ~neigh_q & ~bus_pend;
  assign interim_wr_en   = wr_q;
  assign interim_wr_addr = addr_q;
  assign interim_wr_data = data_q;
  assign neigh_valid     = neigh_q;
  assign neigh_data      = data_q;
  assign bus_data        = data_q;
`ifdef RESULT_DISPATCHER_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q;
  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else if (in_valid & ~in_ready & ~&stall_q) stall_q <= stall_q + STALL_W'(1);
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule
